// File: rtl/stream_packer.sv
// stream_packer: packs RATIO narrow beats into one DW-wide word for the streaming FIFO.
// Short packets closed by in_last are zero-padded. A credit counter mirrors the free
// FIFO slots so the input stalls instead of overrunning a FIFO that has no full flag.
module stream_packer #(
    parameter int unsigned DW      = 32,
    parameter int unsigned IW      = 8,
    parameter int unsigned RATIO   = DW / IW,
    parameter int unsigned LEN_LOG = 2,
    parameter int unsigned LEN     = 1 << LEN_LOG
) (
    input  logic               WCLK,
    input  logic               RST_X,
    input  logic               WRST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IW-1:0]      in_data,
    input  logic               in_last,
    input  logic               credit_ret,
    output logic               enq,
    output logic [DW-1:0]      dout,
    output logic [LEN_LOG:0]   level,
    output logic               ovf_err
);

    localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LEN_LOG:0] LenC  = (LEN_LOG + 1)'(LEN);
    localparam logic [CW-1:0]    LastC = CW'(RATIO - 1);

    logic [DW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic [LEN_LOG:0] cred_q;
    logic             enq_q;
    logic [DW-1:0]    dout_q;
    logic             ovf_q;

    logic             accept;
    logic             complete;
    logic             cred_full;
    logic             inc;
    logic             dec;
    logic             ovf_set;
    logic [DW-1:0]    acc_ins;
    logic [DW-1:0]    word_out;
    logic [LEN_LOG:0] cred_d;

    // Ready depends only on state and the synchronous clear, never on the beat itself.
    always_comb begin
        in_ready  = (cred_q != '0) && !WRST;
        accept    = in_valid && in_ready;
        complete  = accept && ((cnt_q == LastC) || in_last);
        cred_full = (cred_q == LenC);
        dec       = complete;
        // A return with no outstanding words is an overflow and must not raise cred past LEN.
        ovf_set   = credit_ret && !WRST && cred_full && !dec;
        inc       = credit_ret && !WRST && !(cred_full && !dec);
    end

    // Insert the beat at lane cnt; the outgoing word also zeroes every lane above cnt.
    always_comb begin
        acc_ins  = acc_q;
        word_out = '0;
        for (int unsigned l = 0; l < RATIO; l++) begin
            if (CW'(l) == cnt_q) begin
                acc_ins[l*IW +: IW] = in_data;
            end
            if (CW'(l) <= cnt_q) begin
                word_out[l*IW +: IW] = acc_ins[l*IW +: IW];
            end
        end
    end

    // Credit next state: simultaneous dec and inc cancel.
    always_comb begin
        cred_d = cred_q;
        if (dec && !inc) begin
            cred_d = cred_q - 1'b1;
        end else if (inc && !dec) begin
            cred_d = cred_q + 1'b1;
        end
    end

    // Packing state, output word register and credit counter.
    always_ff @(posedge WCLK or negedge RST_X) begin
        if (!RST_X) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            cred_q <= LenC;
            enq_q  <= 1'b0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else if (WRST) begin
            // Partial word is dropped; dout keeps the last word written.
            acc_q  <= '0;
            cnt_q  <= '0;
            cred_q <= LenC;
            enq_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cred_q <= cred_d;
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            if (complete) begin
                dout_q <= word_out;
                enq_q  <= 1'b1;
                acc_q  <= '0;
                cnt_q  <= '0;
            end else begin
                enq_q <= 1'b0;
                if (accept) begin
                    acc_q <= acc_ins;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Outputs: everything registered except level, which is derived from cred.
    always_comb begin
        enq     = enq_q;
        dout    = dout_q;
        ovf_err = ovf_q;
        level   = LenC - cred_q;
    end

endmodule
